sub_mon_cmp_fifo: RTL
=====================

SUB_MON_CMP_FIFO -- requirements
Module: sub_mon_cmp_fifo

Interface
REQ-001 SHALL have parameter ELEMENT_NUM, default 32, elements per row.
REQ-002 SHALL have parameter ELEMENT_WIDTH, default 16, bits per element.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, expected-row buffer depth, power of two >=2.
REQ-004 SHALL have parameter CMP_MODE, default 1: 0 exact; 1 exact plus signed-zero equivalence; 2 absolute tolerance.
REQ-005 SHALL have parameter TOL, default 1, max unsigned |exp-din| per element in mode 2.
REQ-006 SHALL have parameter TOTAL_NUM, default 64, rows expected before done.
REQ-007 SHALL have parameter MAX_ERR, default 1, mismatched rows that force FAIL.
REQ-008 SHALL have parameter TIMEOUT, default 1000, idle cycles in RUN before FAIL; 0 disables.
REQ-009 clk  input  1  single clock, rising edge.
REQ-010 rst_n  input  1  reset, asynchronous, active-low.
REQ-011 exp_vld  input  1  expected row valid.
REQ-012 exp_din  input  ELEMENT_NUM*ELEMENT_WIDTH  expected row, element i at bits [i*W +: W].
REQ-013 exp_rdy  output  1  FIFO not full.
REQ-014 ivld  input  1  DUT row valid.
REQ-015 din  input  ELEMENT_NUM*ELEMENT_WIDTH  DUT row, same packing.
REQ-016 elem_mask  input  ELEMENT_NUM  1 = element i excluded from compare.
REQ-017 step_num  input  8  tag printed on mismatch.
REQ-018 row_cnt  output  32  DUT rows consumed.
REQ-019 err_cnt  output  16  mismatched rows, saturating at 0xFFFF.
REQ-020 err_flag  output  1  one-cycle pulse, cycle after a mismatched row.
REQ-021 done  output  1  sticky, state DONE.
REQ-022 fail  output  1  sticky, state FAIL.

Function
REQ-023 Push: exp_vld && exp_rdy writes exp_din at write pointer; exp_rdy = !full, from registered occupancy only.
REQ-024 Push when full SHALL be dropped, even if a pop occurs the same cycle.
REQ-025 Pop: ivld with FIFO non-empty in IDLE or RUN compares din to FIFO head and pops it in the same cycle; no push-to-compare bypass.
REQ-026 Element match, mode 0: exp==din; mode 1: exp==din, or both in {0, 1<<(W-1)}; mode 2: |exp-din| <= TOL, computed in W+1 bits.
REQ-027 Row matches iff every unmasked element matches; all-masked row matches.
REQ-028 Each pop: row_cnt+1; on mismatch err_cnt+1 (saturating), err_flag=1 next cycle, $display of row_cnt, step_num, exp row, din row.
REQ-029 FSM states IDLE, RUN, DONE, FAIL; encoding free.
REQ-030 IDLE->RUN on first accepted push or ivld.
REQ-031 RUN->DONE when a pop makes row_cnt==TOTAL_NUM and err_cnt after that pop < MAX_ERR.
REQ-032 ->FAIL when err_cnt reaches MAX_ERR, ivld with FIFO empty (underrun), idle counter reaches TIMEOUT, or ivld in DONE (excess row); each cause prints a distinct $display.
REQ-033 Idle counter: clears on any ivld and on entry to RUN, increments each RUN cycle without ivld; not active in IDLE, DONE, FAIL.
REQ-034 FAIL takes priority over DONE in the same cycle; DONE and FAIL are terminal until reset.
REQ-035 In DONE/FAIL: no pops; pushes still accepted until full; counters frozen.
REQ-036 Pointers wrap modulo FIFO_DEPTH; occupancy is log2(FIFO_DEPTH)+1 bits.

Reset
REQ-037 rst_n low SHALL asynchronously clear state to IDLE, FIFO to empty, and row_cnt, err_cnt, idle counter, err_flag, done, fail to 0; exp_rdy=1.
REQ-038 Reset mid-operation SHALL discard buffered rows; first post-reset row compares against the first post-reset push.
REQ-039 Deassertion SHALL be sampled synchronously; first push is accepted on the first rising edge with rst_n high.

Verification
REQ-040 TOTAL_NUM=4: push 4 rows, then 4 identical ivld rows -> row_cnt=4, err_cnt=0, done=1 after 4th pop, fail=0.
REQ-041 Mode 1, W=16: exp elem 0x0000, din 0x8000 -> match; exp 0x0001, din 0x8001 -> err_flag pulse, err_cnt=1, fail=1 (MAX_ERR=1).
REQ-042 Mode 2, TOL=1: exp 0x0010 vs din 0x0011 and 0x000F -> match; vs din 0x0012 -> mismatch; mask that element -> match.
REQ-043 FIFO_DEPTH=8: push 9 rows without ivld -> exp_rdy=0 after 8th, 9th dropped; pop 8 -> rows 1..8 in order, ivld 9th -> underrun, fail=1.
REQ-044 TIMEOUT=10: one push and pop, TOTAL_NUM=4, no further ivld -> fail=1 after 10 idle cycles; TIMEOUT=0 -> stays RUN.
REQ-045 Assert rst_n low with 3 rows buffered and err_cnt=1 -> all outputs at reset values immediately, exp_rdy=1, state IDLE.

Source files
------------

// File: rtl/sub_mon_cmp_fifo.sv
// Scoreboard monitor: buffers expected rows in a FIFO and compares them
// against incoming DUT rows, tracking counts and a pass/fail verdict.
module sub_mon_cmp_fifo #(
    parameter int ELEMENT_NUM   = 32,
    parameter int ELEMENT_WIDTH = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int CMP_MODE      = 1,
    parameter int TOL           = 1,
    parameter int TOTAL_NUM     = 64,
    parameter int MAX_ERR       = 1,
    parameter int TIMEOUT       = 1000
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 exp_vld,
    input  logic [ELEMENT_NUM*ELEMENT_WIDTH-1:0] exp_din,
    output logic                                 exp_rdy,
    input  logic                                 ivld,
    input  logic [ELEMENT_NUM*ELEMENT_WIDTH-1:0] din,
    input  logic [ELEMENT_NUM-1:0]               elem_mask,
    input  logic [7:0]                           step_num,
    output logic [31:0]                          row_cnt,
    output logic [15:0]                          err_cnt,
    output logic                                 err_flag,
    output logic                                 done,
    output logic                                 fail
);

    localparam int W  = ELEMENT_WIDTH;
    localparam int RW = ELEMENT_NUM * ELEMENT_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_t;

    state_t state, state_nxt;

    logic [RW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic [31:0]   idle_cnt;

    logic          full, empty, active, push, pop;
    logic [RW-1:0] head;
    logic          row_ok, mis, err_max, err_hit, row_last, underrun, tmo;
    logic [15:0]   err_inc, err_after;
    logic [31:0]   idle_inc;

    // Mode 2 takes the difference in W+1 bits so 0 vs all-ones never wraps.
    function automatic logic elem_ok(input logic [W-1:0] e, input logic [W-1:0] d);
        logic [W:0]   diff;
        logic [W-1:0] nz;
        logic         res;
        nz   = {1'b1, {(W-1){1'b0}}};
        diff = {1'b0, e} - {1'b0, d};
        if (diff[W]) diff = -diff;
        unique case (CMP_MODE)
            0:       res = (e == d);
            1:       res = (e == d) || ((e == '0 || e == nz) && (d == '0 || d == nz));
            default: res = (diff <= (W+1)'(TOL));
        endcase
        return res;
    endfunction

    assign full    = (occ == (AW+1)'(FIFO_DEPTH));
    assign empty   = (occ == '0);
    assign exp_rdy = !full;
    assign active  = (state == S_IDLE) || (state == S_RUN);
    assign push    = exp_vld && !full;
    assign pop     = ivld && !empty && active;
    assign head    = mem[rd_ptr];

    always_comb begin
        row_ok = 1'b1;
        for (int i = 0; i < ELEMENT_NUM; i++) begin
            if (!elem_mask[i] && !elem_ok(head[i*W +: W], din[i*W +: W]))
                row_ok = 1'b0;
        end
    end

    assign mis       = pop && !row_ok;
    assign err_inc   = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
    assign err_after = mis ? err_inc : err_cnt;
    assign err_max   = {16'd0, err_after} >= 32'(MAX_ERR);
    assign err_hit   = mis && err_max;
    assign row_last  = pop && (row_cnt + 32'd1 == 32'(TOTAL_NUM));
    assign underrun  = ivld && empty && active;
    assign idle_inc  = idle_cnt + 32'd1;
    assign tmo       = (TIMEOUT != 0) && (state == S_RUN) && !ivld
                       && (idle_inc == 32'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_RUN: begin
                if (err_hit || underrun || tmo)  state_nxt = S_FAIL;
                else if (row_last && !err_max)   state_nxt = S_DONE;
                else if (push || ivld)           state_nxt = S_RUN;
            end
            S_DONE:  if (ivld) state_nxt = S_FAIL;
            default: state_nxt = S_FAIL;
        endcase
    end

    always_comb begin
        done = (state == S_DONE);
        fail = (state == S_FAIL);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= exp_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            row_cnt  <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            idle_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            occ      <= occ + (AW+1)'(push) - (AW+1)'(pop);
            if (pop) row_cnt <= row_cnt + 32'd1;
            if (mis) err_cnt <= err_inc;
            err_flag <= mis;
            if (state == S_RUN)
                idle_cnt <= ivld ? 32'd0 : idle_inc;
            else if (state_nxt == S_RUN)
                idle_cnt <= 32'd0;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            if (mis)
                $display("sub_mon_cmp_fifo: row %0d step %0d differs: exp=%h din=%h",
                         row_cnt, step_num, head, din);
            if (state != S_FAIL && state_nxt == S_FAIL) begin
                if (err_hit)  $display("sub_mon_cmp_fifo: stop, error limit %0d reached", MAX_ERR);
                if (underrun) $display("sub_mon_cmp_fifo: stop, row with no expected row (underrun)");
                if (tmo)      $display("sub_mon_cmp_fifo: stop, timeout after %0d idle cycles", TIMEOUT);
                if (state == S_DONE)
                    $display("sub_mon_cmp_fifo: stop, excess row after completion");
            end
        end
    end
`endif

endmodule
